// File: rtl/master_slave_jk_ff.sv
// Master-slave JK flip-flop bank built from two level-sensitive latches per bit.
// The master is open while clk is high and the slave is open while clk is low,
// so Q changes only on the falling edge of clk. Reset clears both latches
// asynchronously, and it overrides every other input.
module master_slave_jk_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] qn_bar
);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;

  // Per-bit JK rule. s acts as J and r acts as K.
  // The rule is applied to the currently held slave value.
  function automatic logic [WIDTH-1:0] jk_next(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] j,
    input logic [WIDTH-1:0] k
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   nxt[i] = cur[i];
        2'b01:   nxt[i] = 1'b0;
        2'b10:   nxt[i] = 1'b1;
        default: nxt[i] = ~cur[i];
      endcase
    end
    return nxt;
  endfunction

  // Master latch: open during the high phase.
  // It looks only at q, which the closed slave holds stable, so there is no race-around.
  always_latch begin
    if (rst)
      m <= '0;
    else if (clk)
      m <= jk_next(q, s, r);
  end

  // Slave latch: open during the low phase. It copies the master value frozen at the falling edge.
  always_latch begin
    if (rst)
      q <= '0;
    else if (!clk)
      q <= m;
  end

  // The outputs are taken directly from the slave. The complement is formed combinationally and is not stored.
  assign qn     = q;
  assign qn_bar = ~q;

endmodule

// File: tb/tb_master_slave_jk_ff.sv
// Testbench for master_slave_jk_ff with WIDTH=4. It uses directed and randomized steps.
// A behavioural model applies Q' = (J & ~Q) | (~K & Q) once per falling edge.
module tb_master_slave_jk_ff;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic [3:0] r;
  logic [3:0] qn;
  logic [3:0] qn_bar;

  int checks;
  int failures;
  logic [3:0] model_q;

  master_slave_jk_ff #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .s      (s),
    .r      (r),
    .qn     (qn),
    .qn_bar (qn_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_qn"}, qn, model_q);
    check({tag, "_qn_bar"}, qn_bar, ~model_q);
  endtask

  // One clock period. The inputs are applied in the middle of the high phase.
  // The outputs are checked just after the rising edge, where they must be unchanged,
  // and again just after the falling edge.
  task automatic cycle(input string tag, input logic [3:0] sv, input logic [3:0] rv);
    @(posedge clk);
    #1 check({tag, "_rise"}, qn, model_q);
    #1 s = sv; r = rv;
    @(negedge clk);
    model_q = (sv & ~model_q) | (~rv & model_q);
    #1 check_outputs(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_q  = '0;
    rst = 1'b1;
    s   = 4'hF;
    r   = 4'hF;

    // Reset is held through several clock periods with s=r=1. The flip-flop must not toggle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2 check_outputs("reset_high");
      @(negedge clk);
      #2 check_outputs("reset_low");
    end

    // Reset is released during the low phase with the inputs idle.
    s = '0;
    r = '0;
    rst = 1'b0;
    #1 check_outputs("release_low");

    // Set, then hold the value for 3 periods.
    cycle("set", 4'hF, 4'h0);
    check("set_const", qn, 4'hF);
    for (int i = 0; i < 3; i++) cycle("hold", 4'h0, 4'h0);
    check("hold_const", qn, 4'hF);

    // Clear.
    cycle("clear", 4'h0, 4'hF);
    check("clear_const", qn, 4'h0);

    // Toggle for 4 periods. The expected sequence is 1,0,1,0.
    for (int i = 0; i < 4; i++) begin
      cycle("toggle", 4'hF, 4'hF);
      check("toggle_const", qn, (i % 2 == 0) ? 4'hF : 4'h0);
    end

    // Pulse s only during the low phase. The flip-flop must ignore it.
    cycle("idle", 4'h0, 4'h0);
    #1 s = 4'hF;
    #2 s = 4'h0;
    cycle("lowpulse", 4'h0, 4'h0);
    check("lowpulse_const", qn, 4'h0);

    // Assert reset in the middle of the high phase with s=1. Q must clear immediately.
    cycle("preset", 4'h5, 4'h0);
    @(posedge clk);
    #2 s = 4'hF; r = 4'h0; rst = 1'b1;
    model_q = '0;
    #1 check_outputs("rst_async_high");
    @(negedge clk);
    #1 check_outputs("rst_async_low");
    rst = 1'b0;
    s = '0;

    // WIDTH=4 mixed operation starting from 0011.
    cycle("load0011", 4'b0011, 4'b0000);
    check("load0011_const", qn, 4'b0011);
    cycle("mixed", 4'b1010, 4'b0110);
    check("mixed_qn_const", qn, 4'b1001);
    check("mixed_qnbar_const", qn_bar, 4'b0110);

    // Randomized steps. Random noise is driven on s and r during the low phase of each period.
    for (int i = 0; i < 40; i++) begin
      s = 4'($urandom);
      r = 4'($urandom);
      cycle("random", 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
